// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation ADC controller built from the board's R-2R DAC plus
// an external comparator. Each conversion walks the code MSB first, holding every trial code
// for SETTLE_CYC cycles before reading the comparator.
//
// Ports:
//   sys_clk    system clock
//   sys_rst    asynchronous reset, active-high
//   start      conversion request (level, one cycle is enough; ignored while converting)
//   auto_mode  free-running conversions when high
//   cmp_in     asynchronous comparator output, 1 means Vin >= Vdac
//   dac_out    code driven to the R-2R DAC
//   result     last completed conversion
//   busy       high while a conversion is in progress
//   done       one-cycle pulse when result updates
module sar_adc_ctrl #(
   parameter int unsigned DAC_W      = 4,
   parameter int unsigned SETTLE_CYC = 1024
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             start,
   input  logic             auto_mode,
   input  logic             cmp_in,
   output logic [DAC_W-1:0] dac_out,
   output logic [DAC_W-1:0] result,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CntW = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
   localparam int unsigned IdxW = (DAC_W > 2) ? $clog2(DAC_W) : 1;

   localparam logic [CntW-1:0]  CntMax  = CntW'(SETTLE_CYC - 1);
   localparam logic [IdxW-1:0]  IdxMsb  = IdxW'(DAC_W - 1);
   localparam logic [DAC_W-1:0] MsbOnly = {1'b1, {(DAC_W-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

   state_e           state;
   logic             cmp_meta;
   logic             cmp_s;
   logic [CntW-1:0]  settle_cnt;
   logic [IdxW-1:0]  bit_idx;
   logic [DAC_W-1:0] trial_dec;

   // Trial code after the decision edge: drop the bit under test if Vin < Vdac, then raise
   // the next lower bit as the new trial (nothing to raise on the last bit).
   always_comb begin
      trial_dec = dac_out;
      if (!cmp_s) begin
         trial_dec[bit_idx] = 1'b0;
      end
      if (bit_idx != '0) begin
         trial_dec[bit_idx - 1'b1] = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= StIdle;
         cmp_meta   <= 1'b0;
         cmp_s      <= 1'b0;
         settle_cnt <= '0;
         bit_idx    <= IdxMsb;
         dac_out    <= '0;
         result     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         // 2-FF synchronizer; its latency is absorbed by the settle window
         cmp_meta <= cmp_in;
         cmp_s    <= cmp_meta;
         done     <= 1'b0;

         case (state)
            StIdle, StDone: begin
               if (start || auto_mode) begin
                  state      <= StConv;
                  dac_out    <= MsbOnly;
                  bit_idx    <= IdxMsb;
                  settle_cnt <= '0;
                  busy       <= 1'b1;
               end else begin
                  state   <= StIdle;
                  dac_out <= result;
               end
            end

            StConv: begin
               if (settle_cnt == CntMax) begin
                  settle_cnt <= '0;
                  dac_out    <= trial_dec;
                  if (bit_idx != '0) begin
                     bit_idx <= bit_idx - 1'b1;
                  end else begin
                     result <= trial_dec;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     state  <= StDone;
                  end
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end

            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Testbench for sar_adc_ctrl (DAC_W=4, SETTLE_CYC=4) with an ideal comparator model.
// Expected results and done timing are queued when a conversion is launched; a monitor pops
// and compares on every done pulse.
module tb_sar_adc_ctrl;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b0;
   logic       start = 1'b0;
   logic       auto_mode = 1'b0;
   logic       cmp_in;
   logic [3:0] dac_out;
   logic [3:0] result;
   logic       busy;
   logic       done;
   logic [4:0] vin_code = '0;   // one bit wider than the DAC to model over-range inputs

   typedef struct {
      int res;
      int edge_n;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   done_cnt = 0;

   assign cmp_in = (vin_code >= {1'b0, dac_out});

   sar_adc_ctrl #(
      .DAC_W      (4),
      .SETTLE_CYC (4)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .start     (start),
      .auto_mode (auto_mode),
      .cmp_in    (cmp_in),
      .dac_out   (dac_out),
      .result    (result),
      .busy      (busy),
      .done      (done)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Ideal SAR converges on the largest code not above Vin.
   function automatic int ref_sar(input int vin);
      return (vin > 15) ? 15 : vin;
   endfunction

   // Monitor / scoreboard
   always @(negedge sys_clk) begin
      if (!sys_rst && done === 1'b1) begin
         done_cnt++;
         if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = q.pop_front();
            check("result", result, e.res);
            check("done_edge", cyc, e.edge_n);
         end
      end
   end

   task automatic wait_done(input int d0, input int limit);
      for (int i = 0; i < limit && done_cnt == d0; i++) begin
         @(negedge sys_clk);
         #1;
      end
      if (done_cnt == d0) check("done_timeout", 0, 1);
   endtask

   // One start-triggered conversion. check_seq walks dac_out/busy cycle by cycle;
   // extra_starts re-pulses start at edges 3 and 9, which must be ignored.
   task automatic convert(input int vin, input bit check_seq, input bit extra_starts);
      int c;
      int d0;
      int acc;
      int seq[4];
      acc = 0;
      for (int b = 3; b >= 0; b--) begin
         seq[3-b] = acc | (1 << b);
         if (vin >= seq[3-b]) acc = seq[3-b];
      end
      @(posedge sys_clk);
      #1;
      vin_code = 5'(vin);
      start    = 1'b1;
      c        = cyc;
      d0       = done_cnt;
      q.push_back('{res: ref_sar(vin), edge_n: c + 17});
      @(posedge sys_clk);
      #1;
      start = 1'b0;
      if (check_seq) begin
         for (int k = 0; k < 16; k++) begin
            check($sformatf("dac_seq_%0d", k), dac_out, seq[k/4]);
            check($sformatf("busy_%0d", k), busy, 1);
            @(posedge sys_clk);
            #1;
         end
         check("busy_after", busy, 0);
         check("done_after", done, 1);
      end else if (extra_starts) begin
         repeat (2) @(posedge sys_clk);
         #1 start = 1'b1;
         @(posedge sys_clk);
         #1 start = 1'b0;
         repeat (5) @(posedge sys_clk);
         #1 start = 1'b1;
         @(posedge sys_clk);
         #1 start = 1'b0;
      end
      wait_done(d0, 40);
      repeat (4) @(negedge sys_clk);
      #1;
      check("done_count", done_cnt - d0, 1);
      check("idle_busy", busy, 0);
      check("idle_dac_holds", dac_out, ref_sar(vin));
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int c;
      int d0;

      // Reset asserted before any clock edge must clear outputs immediately
      #1 sys_rst = 1'b1;
      #1;
      check("rst_dac", dac_out, 0);
      check("rst_result", result, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      repeat (10) @(negedge sys_clk);
      #1;
      check("idle10_busy", busy, 0);
      check("idle10_done", done, 0);
      check("idle10_dac", dac_out, 0);
      check("idle10_no_done", done_cnt, 0);

      // Directed conversions and boundaries
      convert(11, 1'b1, 1'b0);
      convert(0, 1'b0, 1'b0);
      convert(15, 1'b0, 1'b0);
      convert(8, 1'b0, 1'b0);
      convert(19, 1'b0, 1'b0);
      convert(11, 1'b0, 1'b1);

      repeat (8) convert(int'($urandom_range(0, 20)), 1'b0, 1'b0);

      // Back-to-back auto conversions: 17 cycles apart, never idle in between
      @(posedge sys_clk);
      #1;
      vin_code  = 5'd3;
      auto_mode = 1'b1;
      c         = cyc;
      d0        = done_cnt;
      q.push_back('{res: 3, edge_n: c + 17});
      wait_done(d0, 40);
      check("auto_done_busy", busy, 0);
      vin_code = 5'd12;
      q.push_back('{res: 12, edge_n: c + 34});
      d0 = done_cnt;
      @(negedge sys_clk);
      #1;
      check("auto_no_idle_busy", busy, 1);
      check("auto_restart_dac", dac_out, 8);
      repeat (2) @(negedge sys_clk);
      #1 auto_mode = 1'b0;
      wait_done(d0, 40);
      repeat (4) @(negedge sys_clk);
      #1;
      check("auto_end_idle", busy, 0);
      check("auto_end_dac", dac_out, 12);

      // Reset at edge 7 of a conversion aborts it without a done
      @(posedge sys_clk);
      #1;
      vin_code = 5'd11;
      start    = 1'b1;
      d0       = done_cnt;
      @(posedge sys_clk);
      #1 start = 1'b0;
      repeat (7) @(posedge sys_clk);
      #2 sys_rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_dac", dac_out, 0);
      check("abort_result", result, 0);
      check("abort_done", done, 0);
      @(posedge sys_clk);
      #3 sys_rst = 1'b0;
      repeat (30) @(negedge sys_clk);
      #1;
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_result_held", result, 0);
      convert(11, 1'b0, 1'b0);

      check("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
